seg7_scan_decoder: RTL and testbench

- Reads back a multiplexed 7-segment display bus and recovers the displayed digits. The bus carries a segment pattern plus a one-hot digit-select.
- Inverse of our BCD-to-segment conversion; used for display loopback checking and for reading scanned panels.
- Samples each scan slot once, decodes the pattern to a 4-bit code and debounces it per digit.
- Delivers complete frames over a valid/ready handshake, plus an error flag for illegal patterns.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_pattern_decode.sv | 34 +++
 rtl/seg7_scan_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan decoder.
// Segment patterns use bit6=a ... bit0=g, active-high, matching the encoder.
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] code_t;

  localparam seg_t SEG_0     = 7'h7E;
  localparam seg_t SEG_1     = 7'h30;
  localparam seg_t SEG_2     = 7'h6D;
  localparam seg_t SEG_3     = 7'h79;
  localparam seg_t SEG_4     = 7'h33;
  localparam seg_t SEG_5     = 7'h5B;
  localparam seg_t SEG_6     = 7'h5F;
  localparam seg_t SEG_7     = 7'h70;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h73;
  localparam seg_t SEG_BLANK = 7'h00;

  localparam code_t CODE_BLANK = 4'hF;

  typedef enum logic {
    ST_COLLECT,
    ST_OFFER
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational segment-pattern to code lookup.
// Single source of the decode table.
// Ports:
//   segments  in   seg_t   pattern, bit6=a ... bit0=g
//   code      out  code_t  decoded digit, CODE_BLANK for an unlit digit
//   legal     out  1       pattern is in the table
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  seg_t  segments,
  output code_t code,
  output logic  legal
);

  always_comb begin
    code  = CODE_BLANK;
    legal = 1'b1;
    case (segments)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers digits from a multiplexed 7-segment bus.
// Each one-hot scan slot is sampled once after settling, decoded, debounced
// per digit, and complete frames are offered over valid/ready.
// Optional: define SEG7_DP_EN to add the decimal point (dp in, frame_dp out).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   segments       segment pattern (bit6=a ... bit0=g)
//   digit_sel      one-hot digit enable, bit0 = rightmost digit
//   frame_digits   decoded codes, digit i at [4i+3:4i]
//   frame_valid    frame available; frame_ready accepts it
//   pattern_err    one-cycle pulse after an illegal sample
//   err_digit      digit index of the last illegal sample (held)
//   dp, frame_dp   decimal point in / per-digit out (SEG7_DP_EN only)
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS    = 4,
  parameter  int SETTLE_CYCLES = 2,
  parameter  int STABLE_SCANS  = 3,
  localparam int EW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              segments,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
`ifdef SEG7_DP_EN
  input  logic                    dp,
  output logic [NUM_DIGITS-1:0]   frame_dp,
`endif
  output logic [4*NUM_DIGITS-1:0] frame_digits,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    pattern_err,
  output logic [EW-1:0]           err_digit
);

`ifdef SEG7_DP_EN
  localparam int KW = 5;  // {dp, code}
`else
  localparam int KW = 4;
`endif
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int SW = $clog2(STABLE_SCANS + 1);

  // ---------------- slot settle and sample ----------------
  logic [NUM_DIGITS-1:0] prev_sel;
  logic [CW-1:0]         settle_cnt;
  logic                  sel_stable, sample_now;
  logic [EW-1:0]         sel_idx;
  code_t                 dec_code;
  logic                  dec_legal;
  logic [KW-1:0]         cur_key;

  logic                  smp_valid, smp_legal;
  logic [EW-1:0]         smp_idx;
  logic [KW-1:0]         smp_key;

  seg7_pattern_decode u_decode (
    .segments(segments),
    .code    (dec_code),
    .legal   (dec_legal)
  );

`ifdef SEG7_DP_EN
  assign cur_key = {dp, dec_code};
`else
  assign cur_key = dec_code;
`endif

  assign sel_stable = $onehot(digit_sel) && (digit_sel == prev_sel);
  // Sample on the edge where the counter would reach SETTLE_CYCLES; it then
  // saturates so the slot is never sampled twice.
  assign sample_now = sel_stable && (settle_cnt == CW'(SETTLE_CYCLES - 1));

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (digit_sel[i]) sel_idx = EW'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_sel   <= '0;
      settle_cnt <= '0;
      smp_valid  <= 1'b0;
      smp_legal  <= 1'b0;
      smp_idx    <= '0;
      smp_key    <= '0;
    end else begin
      prev_sel  <= digit_sel;
      smp_valid <= sample_now;
      if (!sel_stable)
        settle_cnt <= '0;
      else if (settle_cnt != CW'(SETTLE_CYCLES))
        settle_cnt <= settle_cnt + CW'(1);
      if (sample_now) begin
        smp_idx   <= sel_idx;
        smp_key   <= cur_key;
        smp_legal <= dec_legal;
      end
    end
  end

  // ---------------- per-digit debounce ----------------
  logic [KW-1:0]         cand     [NUM_DIGITS];
  logic [SW-1:0]         match    [NUM_DIGITS];
  logic [KW-1:0]         accepted [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        cand[i]     <= '0;
        match[i]    <= '0;
        accepted[i] <= '0;
      end
      seen        <= '0;
      pattern_err <= 1'b0;
      err_digit   <= '0;
    end else begin
      pattern_err <= 1'b0;
      if (smp_valid) begin
        if (!smp_legal) begin
          pattern_err    <= 1'b1;
          err_digit      <= smp_idx;
          match[smp_idx] <= '0;
        end else if (smp_key == cand[smp_idx]) begin
          if (match[smp_idx] != SW'(STABLE_SCANS)) begin
            match[smp_idx] <= match[smp_idx] + SW'(1);
            if (match[smp_idx] == SW'(STABLE_SCANS - 1)) begin
              accepted[smp_idx] <= cand[smp_idx];
              seen[smp_idx]     <= 1'b1;
            end
          end
        end else begin
          cand[smp_idx]  <= smp_key;
          match[smp_idx] <= SW'(1);
          if (STABLE_SCANS == 1) begin
            accepted[smp_idx] <= smp_key;
            seen[smp_idx]     <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------- frame FSM ----------------
  state_t                  state;
  logic                    sent_any;
  logic [4*NUM_DIGITS-1:0] acc_digits;
  logic [NUM_DIGITS-1:0]   acc_dp;
  logic                    differs, offer_cond;

  always_comb begin
    acc_digits = '0;
    acc_dp     = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      acc_digits[4*i +: 4] = accepted[i][3:0];
      acc_dp[i]            = accepted[i][KW-1];
    end
  end

`ifdef SEG7_DP_EN
  assign differs = (acc_digits != frame_digits) || (acc_dp != frame_dp);
`else
  assign differs = (acc_digits != frame_digits);
`endif
  // frame_digits doubles as the last delivered frame while collecting.
  assign offer_cond = (&seen) && (!sent_any || differs);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_COLLECT;
      frame_digits <= '1;
      frame_valid  <= 1'b0;
      sent_any     <= 1'b0;
`ifdef SEG7_DP_EN
      frame_dp     <= '0;
`endif
    end else begin
      // COLLECT and a completed transfer in OFFER share one decision, which
      // gives back-to-back re-entry into OFFER without an idle cycle.
      if (state == ST_COLLECT || frame_ready) begin
        if (offer_cond) begin
          state        <= ST_OFFER;
          frame_digits <= acc_digits;
          frame_valid  <= 1'b1;
          sent_any     <= 1'b1;
`ifdef SEG7_DP_EN
          frame_dp     <= acc_dp;
`endif
        end else begin
          state       <= ST_COLLECT;
          frame_valid <= 1'b0;
        end
      end
    end
  end

`ifndef SEG7_DP_EN
  logic unused_dp;
  assign unused_dp = ^acc_dp;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed self-checking bench for seg7_scan_decoder
// (NUM_DIGITS=4, SETTLE_CYCLES=2, STABLE_SCANS=3) and the decode table.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  segments;
  logic [3:0]  digit_sel;
  logic        frame_ready;
  logic [15:0] frame_digits;
  logic        frame_valid;
  logic        pattern_err;
  logic [1:0]  err_digit;
`ifdef SEG7_DP_EN
  logic        dp;
  logic [3:0]  frame_dp;
`endif

  seg_t  dec_in;
  code_t dec_out;
  logic  dec_ok;

  int tests = 0;
  int fails = 0;
  int err_pulses = 0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .NUM_DIGITS   (4),
    .SETTLE_CYCLES(2),
    .STABLE_SCANS (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .segments    (segments),
    .digit_sel   (digit_sel),
`ifdef SEG7_DP_EN
    .dp          (dp),
    .frame_dp    (frame_dp),
`endif
    .frame_digits(frame_digits),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .pattern_err (pattern_err),
    .err_digit   (err_digit)
  );

  seg7_pattern_decode u_table (
    .segments(dec_in),
    .code    (dec_out),
    .legal   (dec_ok)
  );

  always @(negedge clk) if (pattern_err === 1'b1) err_pulses++;

  // ---- stimulus helpers (all start and end on a falling edge) ----
  task automatic idle(input int n);
    digit_sel = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_slot(input int idx, input logic [6:0] seg, input logic d, input int hold);
    logic [3:0] s;
    s = '0;
    s[idx] = 1'b1;
    digit_sel = s;
    segments  = seg;
`ifdef SEG7_DP_EN
    dp = d;
`endif
    repeat (hold) @(negedge clk);
  endtask

  task automatic scan_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [3:0] dpm, input int n);
    repeat (n) begin
      scan_slot(0, s0, dpm[0], 3);
      scan_slot(1, s1, dpm[1], 3);
      scan_slot(2, s2, dpm[2], 3);
      scan_slot(3, s3, dpm[3], 3);
    end
  endtask

  // ---- tests ----
  task automatic test_reset;
    rst = 1'b1; frame_ready = 1'b0; digit_sel = '0; segments = '0;
`ifdef SEG7_DP_EN
    dp = 1'b0;
`endif
    repeat (3) @(negedge clk);
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
    tests++; if (frame_digits !== 16'hFFFF) begin fails++; $display("FAIL reset_digits: got %h want ffff", frame_digits); end
    tests++; if (pattern_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", pattern_err); end
    tests++; if (err_digit !== 2'd0) begin fails++; $display("FAIL reset_err_digit: got %0d want 0", err_digit); end
`ifdef SEG7_DP_EN
    tests++; if (frame_dp !== 4'b0000) begin fails++; $display("FAIL reset_dp: got %b want 0000", frame_dp); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_decode_table;
    logic [6:0] pats  [14] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F,
                               7'h70, 7'h7F, 7'h73, 7'h00, 7'h01, 7'h7D, 7'h3F};
    logic [3:0] codes [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                               4'h7, 4'h8, 4'h9, 4'hF, 4'hF, 4'hF, 4'hF};
    logic       oks   [14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      dec_in = pats[i];
      #1;
      tests++;
      if (dec_ok !== oks[i] || (oks[i] && dec_out !== codes[i])) begin
        fails++;
        $display("FAIL decode_%h: got code %h legal %b want code %h legal %b",
                 pats[i], dec_out, dec_ok, codes[i], oks[i]);
      end
    end
  endtask

  task automatic test_first_frame;
    scan_frame(7'h30, 7'h6D, 7'h79, 7'h33, 4'b0000, 3);
    digit_sel = '0;
    @(negedge clk);
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL latency_early: valid %b want 0 one cycle after sample", frame_valid); end
    @(negedge clk);
    tests++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL latency_valid: valid %b want 1 two cycles after sample", frame_valid); end
    tests++; if (frame_digits !== 16'h4321) begin fails++; $display("FAIL first_frame: got %h want 4321", frame_digits); end
  endtask

  task automatic test_back_to_back;
    frame_ready = 1'b0;
    scan_frame(7'h70, 7'h6D, 7'h79, 7'h33, 4'b0000, 3);
    idle(3);
    tests++; if (frame_valid !== 1'b1 || frame_digits !== 16'h4321) begin
      fails++; $display("FAIL offer_hold: valid %b digits %h want 1 4321", frame_valid, frame_digits); end
    frame_ready = 1'b1;
    @(negedge clk);
    tests++; if (frame_valid !== 1'b1 || frame_digits !== 16'h4327) begin
      fails++; $display("FAIL b2b_frame: valid %b digits %h want 1 4327", frame_valid, frame_digits); end
    @(negedge clk);
    frame_ready = 1'b0;
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL b2b_drop: valid %b want 0", frame_valid); end
  endtask

  task automatic test_unstable;
    for (int k = 0; k < 4; k++)
      scan_frame(7'h70, 7'h6D, (k % 2 == 0) ? 7'h7F : 7'h79, 7'h33, 4'b0000, 1);
    idle(3);
    tests++; if (frame_valid !== 1'b0 || frame_digits !== 16'h4327) begin
      fails++; $display("FAIL unstable_hold: valid %b digits %h want 0 4327", frame_valid, frame_digits); end
    scan_frame(7'h70, 7'h6D, 7'h7F, 7'h33, 4'b0000, 3);
    idle(3);
    tests++; if (frame_valid !== 1'b1 || frame_digits !== 16'h4827) begin
      fails++; $display("FAIL steady_frame: valid %b digits %h want 1 4827", frame_valid, frame_digits); end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    @(negedge clk);
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL consume_4827: valid %b want 0", frame_valid); end
  endtask

  task automatic test_illegal;
    int e0;
    e0 = err_pulses;
    scan_slot(1, 7'h01, 1'b0, 3);
    digit_sel = '0;
    @(negedge clk);
    tests++; if (pattern_err !== 1'b1 || err_digit !== 2'd1) begin
      fails++; $display("FAIL illegal_pulse: err %b digit %0d want 1 1", pattern_err, err_digit); end
    @(negedge clk);
    tests++; if (pattern_err !== 1'b0) begin fails++; $display("FAIL illegal_one_cycle: err %b want 0", pattern_err); end
    tests++; if (err_pulses - e0 != 1) begin fails++; $display("FAIL illegal_count: pulses %0d want 1", err_pulses - e0); end
    tests++; if (frame_valid !== 1'b0 || frame_digits !== 16'h4827) begin
      fails++; $display("FAIL illegal_frame: valid %b digits %h want 0 4827", frame_valid, frame_digits); end
    e0 = err_pulses;
    scan_frame(7'h70, 7'h6D, 7'h7F, 7'h00, 4'b0000, 3);
    idle(3);
    tests++; if (err_pulses != e0) begin fails++; $display("FAIL blank_no_err: pulses %0d want 0", err_pulses - e0); end
    tests++; if (frame_valid !== 1'b1 || frame_digits !== 16'hF827) begin
      fails++; $display("FAIL blank_frame: valid %b digits %h want 1 f827", frame_valid, frame_digits); end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_no_sample;
    int e0;
    e0 = err_pulses;
    segments  = 7'h01;
    digit_sel = 4'b0011;
    repeat (6) @(negedge clk);
    idle(6);
    for (int k = 0; k < 8; k++) scan_slot(k % 4, 7'h01, 1'b0, 1);
    for (int k = 0; k < 4; k++) scan_slot(k, 7'h01, 1'b0, 2);
    idle(3);
    tests++; if (err_pulses != e0) begin fails++; $display("FAIL no_sample: pulses %0d want 0", err_pulses - e0); end
    scan_slot(2, 7'h01, 1'b0, 10);
    idle(3);
    tests++; if (err_pulses - e0 != 1) begin fails++; $display("FAIL single_sample: pulses %0d want 1", err_pulses - e0); end
    tests++; if (err_digit !== 2'd2) begin fails++; $display("FAIL err_digit_held: got %0d want 2", err_digit); end
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL no_sample_valid: valid %b want 0", frame_valid); end
  endtask

  task automatic test_reset_offer;
    scan_frame(7'h70, 7'h6D, 7'h7F, 7'h33, 4'b0000, 3);
    idle(3);
    tests++; if (frame_valid !== 1'b1 || frame_digits !== 16'h4827) begin
      fails++; $display("FAIL pre_reset_offer: valid %b digits %h want 1 4827", frame_valid, frame_digits); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (frame_valid !== 1'b0 || frame_digits !== 16'hFFFF) begin
      fails++; $display("FAIL reset_in_offer: valid %b digits %h want 0 ffff", frame_valid, frame_digits); end
    tests++; if (err_digit !== 2'd0) begin fails++; $display("FAIL reset_err_digit2: got %0d want 0", err_digit); end
    idle(10);
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL post_reset_idle: valid %b want 0", frame_valid); end
  endtask

`ifdef SEG7_DP_EN
  task automatic test_dp;
    scan_frame(7'h30, 7'h6D, 7'h79, 7'h33, 4'b0001, 3);
    idle(3);
    tests++; if (frame_valid !== 1'b1 || frame_dp !== 4'b0001 || frame_digits !== 16'h4321) begin
      fails++; $display("FAIL dp_frame: valid %b dp %b digits %h want 1 0001 4321", frame_valid, frame_dp, frame_digits); end
  endtask
`endif

  initial begin
    test_reset;
    test_decode_table;
    test_first_frame;
    test_back_to_back;
    test_unstable;
    test_illegal;
    test_no_sample;
    test_reset_offer;
`ifdef SEG7_DP_EN
    test_dp;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
